// File: rtl/pt_frame_seq.sv
// PT2262 frame sequencer: takes one 12-trit code word and drives cb_gen's state
// input trit by trit, appends sync, and repeats the frame REPEATS times.
module pt_frame_seq #(
    parameter int BIT_CLKS  = 32,
    parameter int SYNC_BITS = 4,
    parameter int REPEATS   = 4
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [23:0] frame_data,
    input  logic        frame_valid,
    output logic        frame_ready,
    input  logic        abort,
    output logic [1:0]  state,
    output logic        tx_en,
    output logic        sym_start,
    output logic        done
);

    localparam int CW = $clog2(BIT_CLKS);
    localparam int SW = $clog2(SYNC_BITS + 1);
    localparam int RW = $clog2(REPEATS + 1);

    localparam logic [CW-1:0] CLK_LAST  = CW'(BIT_CLKS - 1);
    localparam logic [SW-1:0] SYNC_LAST = SW'(SYNC_BITS - 1);
    localparam logic [RW-1:0] REP_LAST  = RW'(REPEATS - 1);
    localparam logic [3:0]    TRIT_LAST = 4'd11;

    localparam logic [1:0] SYM_F    = 2'b10;
    localparam logic [1:0] SYM_SYNC = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DATA = 2'd1,
        SYNC = 2'd2
    } fsm_e;

    fsm_e          fsm_q, fsm_d;
    logic [23:0]   word_q, word_d;
    logic [CW-1:0] clk_cnt_q, clk_cnt_d;
    logic [3:0]    trit_idx_q, trit_idx_d;
    logic [SW-1:0] sync_cnt_q, sync_cnt_d;
    logic [RW-1:0] rep_cnt_q, rep_cnt_d;
    logic [1:0]    state_q, state_d;
    logic          tx_en_q, tx_en_d;
    logic          sym_q, sym_d;
    logic          done_q, done_d;
    logic          ready_q, ready_d;
    logic [3:0]    trit_nxt;

    // Illegal trit 2'b11 is sent as float so sync never appears in the data phase.
    function automatic logic [1:0] trit_sym(input logic [23:0] w, input logic [3:0] idx);
        logic [1:0] t;
        t = w[{idx, 1'b0} +: 2];
        return (t == SYM_SYNC) ? SYM_F : t;
    endfunction

    assign trit_nxt = trit_idx_q + 4'd1;

    always_comb begin
        // NOTE: every next-state signal is defaulted first so no path infers a latch.
        fsm_d      = fsm_q;
        word_d     = word_q;
        clk_cnt_d  = clk_cnt_q;
        trit_idx_d = trit_idx_q;
        sync_cnt_d = sync_cnt_q;
        rep_cnt_d  = rep_cnt_q;
        state_d    = state_q;
        tx_en_d    = tx_en_q;
        ready_d    = ready_q;
        sym_d      = 1'b0;
        done_d     = 1'b0;

        unique case (fsm_q)
            IDLE: begin
                if (frame_valid) begin
                    fsm_d      = DATA;
                    word_d     = frame_data;
                    clk_cnt_d  = '0;
                    trit_idx_d = '0;
                    sync_cnt_d = '0;
                    rep_cnt_d  = '0;
                    state_d    = trit_sym(frame_data, 4'd0);
                    tx_en_d    = 1'b1;
                    sym_d      = 1'b1;
                    ready_d    = 1'b0;
                end
            end
            DATA: begin
                if (abort) begin
                    fsm_d   = IDLE;
                    state_d = SYM_SYNC;
                    tx_en_d = 1'b0;
                    ready_d = 1'b1;
                end else if (clk_cnt_q == CLK_LAST) begin
                    clk_cnt_d = '0;
                    sym_d     = 1'b1;
                    if (trit_idx_q == TRIT_LAST) begin
                        fsm_d      = SYNC;
                        sync_cnt_d = '0;
                        state_d    = SYM_SYNC;
                    end else begin
                        trit_idx_d = trit_nxt;
                        state_d    = trit_sym(word_q, trit_nxt);
                    end
                end else begin
                    clk_cnt_d = clk_cnt_q + 1'b1;
                end
            end
            SYNC: begin
                if (abort) begin
                    fsm_d   = IDLE;
                    state_d = SYM_SYNC;
                    tx_en_d = 1'b0;
                    ready_d = 1'b1;
                end else if (clk_cnt_q == CLK_LAST) begin
                    clk_cnt_d = '0;
                    if (sync_cnt_q == SYNC_LAST) begin
                        rep_cnt_d = rep_cnt_q + 1'b1;
                        if (rep_cnt_q == REP_LAST) begin
                            fsm_d   = IDLE;
                            state_d = SYM_SYNC;
                            tx_en_d = 1'b0;
                            ready_d = 1'b1;
                            done_d  = 1'b1;
                        end else begin
                            // Next repeat starts immediately: no gap cycle in tx_en.
                            fsm_d      = DATA;
                            trit_idx_d = '0;
                            state_d    = trit_sym(word_q, 4'd0);
                            sym_d      = 1'b1;
                        end
                    end else begin
                        sync_cnt_d = sync_cnt_q + 1'b1;
                    end
                end else begin
                    clk_cnt_d = clk_cnt_q + 1'b1;
                end
            end
            default: begin
                fsm_d   = IDLE;
                state_d = SYM_SYNC;
                tx_en_d = 1'b0;
                ready_d = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            fsm_q      <= IDLE;
            word_q     <= '0;
            clk_cnt_q  <= '0;
            trit_idx_q <= '0;
            sync_cnt_q <= '0;
            rep_cnt_q  <= '0;
            state_q    <= SYM_SYNC;
            tx_en_q    <= 1'b0;
            sym_q      <= 1'b0;
            done_q     <= 1'b0;
            ready_q    <= 1'b1;
        end else begin
            // NOTE: non-blocking assignments keep every register sampling pre-edge values.
            fsm_q      <= fsm_d;
            word_q     <= word_d;
            clk_cnt_q  <= clk_cnt_d;
            trit_idx_q <= trit_idx_d;
            sync_cnt_q <= sync_cnt_d;
            rep_cnt_q  <= rep_cnt_d;
            state_q    <= state_d;
            tx_en_q    <= tx_en_d;
            sym_q      <= sym_d;
            done_q     <= done_d;
            ready_q    <= ready_d;
        end
    end

    assign frame_ready = ready_q;
    assign state       = state_q;
    assign tx_en       = tx_en_q;
    assign sym_start   = sym_q;
    assign done        = done_q;

endmodule

// File: tb/tb_pt_frame_seq.sv
// Scoreboard bench for pt_frame_seq: a per-cycle expected output stream is queued
// at each handshake and compared on every falling edge.
module tb_pt_frame_seq;

    localparam int BC = 4;
    localparam int SB = 4;
    localparam int RP = 2;
    localparam logic [5:0] IDLE_V = 6'b100011;  // {ready, done, tx_en, sym_start, state}

    logic        clk;
    logic        reset_n;
    logic [23:0] frame_data;
    logic        frame_valid;
    logic        frame_ready;
    logic        abort;
    logic [1:0]  state;
    logic        tx_en;
    logic        sym_start;
    logic        done;

    logic [23:0] d_data;
    logic        d_valid;
    logic        d_ready;
    logic        d_abort;
    logic [1:0]  d_state;
    logic        d_tx;
    logic        d_sym;
    logic        d_done;

    int n_tests = 0;
    int n_fail  = 0;

    logic [5:0] exp_q[$];
    logic [5:0] mon_e;
    logic       cur_ready_exp = 1'b1;
    int         tx_cnt, sym_cnt, done_cnt;

    int d_run = 0, d_cyc, d_tx_cnt, d_sym_cnt, d_done_cnt, d_bad;

    pt_frame_seq #(.BIT_CLKS(BC), .SYNC_BITS(SB), .REPEATS(RP)) dut (
        .clk(clk), .reset_n(reset_n), .frame_data(frame_data), .frame_valid(frame_valid),
        .frame_ready(frame_ready), .abort(abort), .state(state), .tx_en(tx_en),
        .sym_start(sym_start), .done(done)
    );

    pt_frame_seq dut_dflt (
        .clk(clk), .reset_n(reset_n), .frame_data(d_data), .frame_valid(d_valid),
        .frame_ready(d_ready), .abort(d_abort), .state(d_state), .tx_en(d_tx),
        .sym_start(d_sym), .done(d_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got=%0h exp=%0h", tag, $time, got, exp);
        end
    endtask

    function automatic logic [1:0] exp_trit(input logic [23:0] w, input int k);
        logic [23:0] s;
        s = w >> (2 * k);
        if (s[1:0] == 2'b11) return 2'b10;
        return s[1:0];
    endfunction

    task automatic push_frame(input logic [23:0] w);
        for (int r = 0; r < RP; r++) begin
            for (int k = 0; k < 12; k++)
                for (int c = 0; c < BC; c++)
                    exp_q.push_back({1'b0, 1'b0, 1'b1, c == 0, exp_trit(w, k)});
            for (int c = 0; c < SB * BC; c++)
                exp_q.push_back({1'b0, 1'b0, 1'b1, c == 0, 2'b11});
        end
        exp_q.push_back({1'b1, 1'b1, 1'b0, 1'b0, 2'b11});
    endtask

    // Reference model: its own notion of readiness decides acceptance and abort.
    always @(posedge clk) begin
        if (reset_n) begin
            if (cur_ready_exp && frame_valid) push_frame(frame_data);
            else if (!cur_ready_exp && abort) exp_q.delete();
        end
    end

    always @(negedge reset_n) exp_q.delete();

    always @(negedge clk) begin
        if (!reset_n) begin
            cur_ready_exp = 1'b1;
        end else begin
            mon_e = (exp_q.size() > 0) ? exp_q.pop_front() : IDLE_V;
            cur_ready_exp = mon_e[5];
            check("cycle", {26'd0, frame_ready, done, tx_en, sym_start, state}, {26'd0, mon_e});
            if (tx_en) tx_cnt++;
            if (sym_start) sym_cnt++;
            if (done) done_cnt++;
        end
    end

    // Default-parameter instance: symbol starts must fall every 32 cycles in data, once per sync.
    always @(negedge clk) begin
        if (d_run != 0 && reset_n) begin
            if (d_tx) begin
                int pos;
                logic exp_sym;
                pos = d_cyc % 512;
                exp_sym = (pos < 384) ? (pos % 32 == 0) : (pos == 384);
                if (d_sym !== exp_sym) d_bad++;
                if (d_sym) d_sym_cnt++;
                d_tx_cnt++;
                d_cyc++;
            end
            if (d_done) d_done_cnt++;
        end
    end

    // Caller starts right after a falling edge; returns right after a falling edge.
    task automatic send(input logic [23:0] w, input logic with_abort, input int bound,
                        output int waited);
        frame_data  = w;
        frame_valid = 1'b1;
        abort       = with_abort;
        waited      = 0;
        do begin
            @(posedge clk);
            waited++;
        end while (!cur_ready_exp && waited < bound);
        check("send_accept", {31'd0, cur_ready_exp}, 32'd1);
        @(negedge clk);
        frame_valid = 1'b0;
        abort       = 1'b0;
    endtask

    task automatic wait_drain(input int bound);
        int n = 0;
        while (exp_q.size() > 0 && n < bound) begin
            @(negedge clk);
            n++;
        end
        check("drain", exp_q.size(), 0);
        @(negedge clk);
    endtask

    initial begin
        int w;
        int done_snap;
        #1_000_000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "timeout");
    end

    initial begin
        int w;
        int done_snap;
        reset_n = 1'b0; frame_data = '0; frame_valid = 1'b0; abort = 1'b0;
        d_data = '0; d_valid = 1'b0; d_abort = 1'b0;
        #12;
        check("rst_state", {26'd0, frame_ready, done, tx_en, sym_start, state}, {26'd0, IDLE_V});
        @(negedge clk);
        reset_n = 1'b1;
        repeat (2) @(negedge clk);

        // Basic frame
        tx_cnt = 0; sym_cnt = 0; done_cnt = 0;
        send(24'h000024, 1'b0, 1, w);
        check("basic_wait", w, 1);
        wait_drain(300);
        check("basic_tx_cycles", tx_cnt, 128);
        check("basic_sym_pulses", sym_cnt, 26);
        check("basic_done_pulses", done_cnt, 1);

        // Illegal trit sent as float
        send(24'h000003, 1'b0, 1, w);
        wait_drain(300);

        // Backpressure: second word held until the done cycle
        send(24'h491249, 1'b0, 1, w);
        send(24'h2A6519, 1'b0, 400, w);
        check("bp_accept_cycle", w, 129);
        wait_drain(300);

        // abort together with valid in IDLE: frame still accepted
        done_cnt = 0;
        send(24'h00C3A5, 1'b1, 1, w);
        wait_drain(300);
        check("abort_idle_done", done_cnt, 1);

        // Abort in the sync of the second repeat
        send(24'h965A17, 1'b0, 1, w);
        repeat (115) @(negedge clk);
        check("pre_abort_tx", {31'd0, tx_en}, 32'd1);
        done_snap = done_cnt;
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check("abort_out", {29'd0, frame_ready, tx_en, state}, {29'd0, 1'b1, 1'b0, 2'b11});
        repeat (40) @(negedge clk);
        check("abort_no_done", done_cnt, done_snap);

        // Asynchronous reset in the middle of trit 5
        send(24'h555555, 1'b0, 1, w);
        repeat (21) @(negedge clk);
        #2 reset_n = 1'b0;
        #1 check("rst_async", {26'd0, frame_ready, done, tx_en, sym_start, state}, {26'd0, IDLE_V});
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        check("rst_ready", {31'd0, frame_ready}, 32'd1);
        send(24'h1B6D92, 1'b0, 1, w);
        wait_drain(300);

        // Default parameters on the second instance
        d_cyc = 0; d_tx_cnt = 0; d_sym_cnt = 0; d_done_cnt = 0; d_bad = 0; d_run = 1;
        d_data = 24'h5A6C93; d_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        d_valid = 1'b0;
        w = 0;
        while (d_done_cnt == 0 && w < 3000) begin
            @(negedge clk);
            w++;
        end
        @(negedge clk);
        check("dflt_done", d_done_cnt, 1);
        check("dflt_tx_cycles", d_tx_cnt, 2048);
        check("dflt_sym_pulses", d_sym_cnt, 52);
        check("dflt_sym_spacing", d_bad, 0);
        check("dflt_idle", {29'd0, d_ready, d_tx, d_state}, {29'd0, 1'b1, 1'b0, 2'b11});

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/pt_frame_seq.md
Name: pt_frame_seq

Overview:
Frame sequencer that sits directly upstream of the PT2262 codebit generator (cb_gen). It accepts one 12-trit PT2262 code word through a valid/ready handshake. It then drives cb_gen's 2-bit state input one trit per codebit period, appends the sync symbol, and repeats the whole frame a fixed number of times. It runs on the same divided clock as cb_gen and lets the UART command path transmit complete codes instead of one static state.

Parameters:
BIT_CLKS, 32, clk cycles per codebit; must equal cb_gen's codebit period; minimum 2
SYNC_BITS, 4, number of codebit periods the sync symbol is held (4 x 32 = 128 osc periods = PT2262 sync)
REPEATS, 4, frame transmissions per accepted word; minimum 1, 0 is illegal

Ports:
clk  input  1  sequencer clock, same domain as cb_gen
reset_n  input  1  asynchronous, active-low reset
frame_data  input  24  12 trits, 2 bits each; trit k = frame_data[2k+1:2k]; trit 0 is sent first
frame_valid  input  1  frame_data is valid
frame_ready  output  1  high only in IDLE; a transfer occurs on (frame_valid && frame_ready) at the rising edge
abort  input  1  synchronous cancel of the frame in flight
state  output  2  to cb_gen: 2'b00 = bit 0, 2'b01 = bit 1, 2'b10 = float F, 2'b11 = sync
tx_en  output  1  high while a frame (data or sync) is being emitted; gates the RF output
sym_start  output  1  one-cycle pulse in the first cycle of every symbol (each trit and each sync)
done  output  1  one-cycle pulse after the last sync of the last repeat

Behaviour:
- Reset (async assert, sync release): FSM = IDLE; state = 2'b11; tx_en = 0; sym_start = 0; done = 0; all counters = 0; latched word = 0.
- All outputs are registered.
- FSM has three states: IDLE, DATA, SYNC.
- Counters:
  - clk_cnt: width $clog2(BIT_CLKS)
  - trit_idx: 4 bits, 0..11
  - sync_cnt: width $clog2(SYNC_BITS+1)
  - rep_cnt: width $clog2(REPEATS+1)
- IDLE:
  - frame_ready = 1, state = 2'b11, tx_en = 0.
  - On handshake at edge N: latch frame_data, set trit_idx = 0, rep_cnt = 0, clk_cnt = 0, go to DATA.
  - From edge N+1: state = trit 0, tx_en = 1, sym_start = 1 for exactly that one cycle.
- Trit value 2'b11 inside frame_data is illegal and is transmitted as 2'b10 (F). The sync code is never emitted in the data phase.
- DATA:
  - Each trit is held for exactly BIT_CLKS cycles.
  - When clk_cnt == BIT_CLKS-1: wrap clk_cnt to 0 and advance trit_idx; sym_start pulses on the first cycle of the new symbol.
  - After trit 11 completes: go to SYNC with sync_cnt = 0.
- SYNC:
  - state = 2'b11 and tx_en = 1, held for SYNC_BITS*BIT_CLKS cycles.
  - On completion, increment rep_cnt.
  - If rep_cnt < REPEATS: return to DATA at trit 0, with no gap cycle.
  - Else: go to IDLE; done = 1 for exactly one cycle, coincident with the first IDLE cycle (tx_en = 0, frame_ready = 1).
- Timing:
  - Frame length = (12 + SYNC_BITS)*BIT_CLKS cycles.
  - tx_en stays high continuously for REPEATS*(12 + SYNC_BITS)*BIT_CLKS cycles.
- abort:
  - Sampled at each edge while in DATA/SYNC; next cycle: IDLE, state = 2'b11, tx_en = 0, no done pulse.
  - abort in IDLE has no effect.
  - abort and frame_valid together in IDLE: the frame is accepted; abort is ignored that cycle.
- frame_valid while busy: not accepted (frame_ready = 0); the upstream must hold it. No queueing.
- A new frame can be accepted in the same cycle that done is high; done still pulses.
- reset_n low mid-frame: outputs go to reset values immediately (asynchronously); the latched word is discarded.

Test Plan:
- Bench parameters: BIT_CLKS=4, SYNC_BITS=4, REPEATS=2.
- Basic frame: frame_data=24'h000024 with valid pulsed 1 cycle in IDLE -> from next cycle, state = 00 x4, 01 x4, 10 x4, 00 x36, 11 x16; sequence repeats once; done pulses at cycle 129 after the handshake; tx_en is high exactly 128 cycles; sym_start counts 26 pulses.
- Illegal trit: frame_data=24'h000003 -> trit 0 emitted as 2'b10 for 4 cycles; state is never 2'b11 during DATA.
- Backpressure: frame_valid held high with a second word during transmission -> frame_ready = 0 until done; the second word is accepted in the done cycle and transmission restarts with no gap in tx_en beyond 1 cycle.
- Abort in SYNC of repeat 1: assert abort 1 cycle -> next cycle state = 2'b11, tx_en = 0, frame_ready = 1, done never pulses.
- Reset mid-trit 5: drop reset_n asynchronously -> state = 2'b11 and tx_en = 0 without waiting for a clock edge; after release, frame_ready = 1 and a new frame starts cleanly at trit 0.
- Default parameters (32/4/4): one frame -> tx_en high exactly 2048 cycles; each symbol period is exactly 32 cycles.
